// File: rtl/nbit_mosi_spi_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nbit_mosi_spi_fifo
// Description : FIFO-fed MOSI-only SPI transmitter (SSD1331 command/data path)
//               with CS/DC framing, selectable bit order and CS idle gap.
//               Optional occupancy port o_LEVEL under NBIT_MOSI_SPI_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_mosi_spi_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 0,
    parameter int CS_GAP    = 0
) (
    input  logic             i_SCK,
    input  logic             i_RST,
    input  logic [WIDTH-1:0] i_DATA,
    input  logic             i_DC,
    input  logic             i_VALID,
    output logic             o_READY,
    output logic             o_MOSI,
    output logic             o_CS,
    output logic             o_DC,
    output logic             o_WORD_DONE,
    output logic             o_BUSY
`ifdef NBIT_MOSI_SPI_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] o_LEVEL
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);
    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam int c_GAP_W = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

    localparam logic [c_LVL_W-1:0] c_DEPTH = c_LVL_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_WIDTH = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_GAP_W-1:0] c_GAP   = c_GAP_W'(CS_GAP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // FIFO storage is not reset; pointers and level define its contents.
    logic [WIDTH:0]         mem_q [DEPTH];
    logic [c_PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [c_LVL_W-1:0]     level_q, level_d;

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [c_GAP_W-1:0]     gap_q, gap_d;
    logic                   mosi_q, mosi_d;
    logic                   cs_q, cs_d;
    logic                   dc_q, dc_d;
    logic                   done_q, done_d;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_load;
    logic [WIDTH:0]         w_head;
    logic                   w_first_bit;
    logic [WIDTH-1:0]       w_first_rest;
    logic                   w_next_bit;
    logic [WIDTH-1:0]       w_next_rest;

    assign w_full  = (level_q == c_DEPTH);
    assign w_empty = (level_q == '0);
    assign w_push  = i_VALID && !w_full;
    assign w_head  = mem_q[rd_ptr_q];

    // The shift register holds the bits not yet driven, aligned so the next
    // one is always at the outgoing end.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_first_bit  = w_head[0];
            assign w_first_rest = {1'b0, w_head[WIDTH-1:1]};
            assign w_next_bit   = shreg_q[0];
            assign w_next_rest  = {1'b0, shreg_q[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_first_bit  = w_head[WIDTH-1];
            assign w_first_rest = {w_head[WIDTH-2:0], 1'b0};
            assign w_next_bit   = shreg_q[WIDTH-1];
            assign w_next_rest  = {shreg_q[WIDTH-2:0], 1'b0};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        dc_d    = dc_q;
        done_d  = 1'b0;
        w_load  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                w_load = !w_empty;
            end
            S_SHIFT: begin
                if (cnt_q != c_WIDTH) begin
                    mosi_d  = w_next_bit;
                    shreg_d = w_next_rest;
                    cnt_d   = cnt_q + c_CNT_W'(1);
                    done_d  = (cnt_q == c_LAST);
                end else if (!w_empty && (CS_GAP == 0)) begin
                    w_load = 1'b1;
                end else if (!w_empty) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    gap_d   = c_GAP_W'(1);
                    state_d = S_GAP;
                end else begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                if (gap_q == c_GAP) begin
                    if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + c_GAP_W'(1);
                end
            end
            default: begin
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Shared load action: pop the head entry and drive its first bit now.
        if (w_load) begin
            mosi_d  = w_first_bit;
            shreg_d = w_first_rest;
            cs_d    = 1'b0;
            dc_d    = w_head[WIDTH];
            cnt_d   = c_CNT_W'(1);
            state_d = S_SHIFT;
        end
    end

    assign w_pop = w_load;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + c_LVL_W'(1);
            2'b01:   level_d = level_q - c_LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(negedge i_SCK) begin
        if (!i_RST && w_push) begin
            mem_q[wr_ptr_q] <= {i_DC, i_DATA};
        end
    end

    always_ff @(negedge i_SCK) begin
        if (i_RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            mosi_q   <= 1'b0;
            cs_q     <= 1'b1;
            dc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            mosi_q   <= mosi_d;
            cs_q     <= cs_d;
            dc_q     <= dc_d;
            done_q   <= done_d;
        end
    end

    assign o_READY     = !w_full;
    assign o_MOSI      = mosi_q;
    assign o_CS        = cs_q;
    assign o_DC        = dc_q;
    assign o_WORD_DONE = done_q;
    assign o_BUSY      = !w_empty || (state_q != S_IDLE);

`ifdef NBIT_MOSI_SPI_LEVEL_EN
    assign o_LEVEL = level_q;
`endif

endmodule
`default_nettype wire
